// File: rtl/apb_pix_pkg.sv
// Shared types for the APB pixel master: FSM state encoding, pixel width and
// the registered command record.
package apb_pix_pkg;

    localparam int PIX_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    typedef struct packed {
        logic             write;
        logic [PIX_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_pix_master.sv
// Single-outstanding APB master moving 17-bit lifting pixels between a
// command/response handshake and an APB slave.
// Optional ACCESS timeout abort is enabled by defining APB_MST_TMO_EN.
module apb_pix_master
    import apb_pix_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [PIX_W-1:0]  cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PIX_W-1:0]  rsp_rdata,
    output logic              rsp_err,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if (DATA_W <= PIX_W) begin : g_bad_data_w
        $error("apb_pix_master: DATA_W must exceed PIX_W");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("apb_pix_master: TMO_CYC must be at least 1");
    end

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    apb_cmd_t          r_cmd;
    logic [ADDR_W-1:0] r_paddr;
    logic [PIX_W-1:0]  r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_done;
    logic              w_tmo_hit;
    logic              w_unused;

    assign w_unused = &{1'b0, prdata[DATA_W-1:PIX_W]};
    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    // ACCESS is the only state with psel && penable, so pready here is a valid slave completion.
    assign w_done   = (r_state == ST_ACCESS) && pready;

`ifdef APB_MST_TMO_EN
    localparam int TMO_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [TMO_W-1:0] r_wait_cnt;

    assign w_tmo_hit = (r_state == ST_ACCESS) && !pready
                    && (r_wait_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // NOTE: state and response registers reset asynchronously so the APB bus
    // drops the instant rst rises, even mid-transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                psel        = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_tmo_hit) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paddr     <= '0;
            r_cmd       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr     <= cmd_addr;
                r_cmd.write <= cmd_write;
                r_cmd.wdata <= cmd_wdata;
            end
            if (w_done) begin
                r_rsp_rdata <= r_cmd.write ? '0 : prdata[PIX_W-1:0];
                r_rsp_err   <= pslverr;
            end else if (w_tmo_hit) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign paddr     = r_paddr;
    assign pwrite    = r_cmd.write;
    assign pwdata    = DATA_W'(r_cmd.wdata);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_pix_master.sv
// Directed self-checking bench for apb_pix_master; the timeout scenario runs
// only when APB_MST_TMO_EN is defined (DUT built with TMO_CYC=4).
module tb_apb_pix_master;
    import apb_pix_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [PIX_W-1:0]  cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [PIX_W-1:0]  rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_pix_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TMO_CYC(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command in IDLE and return one tick after the accepting edge.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("issue_cmd_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset state, applied asynchronously before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 17'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait write: psel cycle 1, penable cycle 2, rsp_valid cycle 3.
        pready = 1'b1;
        issue(1'b1, 32'h10, 17'h1ABCD);
        check("w0_c1_psel", psel, 1'b1);
        check("w0_c1_penable", penable, 1'b0);
        check("w0_c1_cmd_ready", cmd_ready, 1'b0);
        check("w0_c1_paddr", paddr, 32'h10);
        check("w0_c1_pwrite", pwrite, 1'b1);
        check("w0_c1_pwdata", pwdata, 32'h0001ABCD);
        step();
        check("w0_c2_psel", psel, 1'b1);
        check("w0_c2_penable", penable, 1'b1);
        check("w0_c2_rsp_valid", rsp_valid, 1'b0);
        step();
        check("w0_c3_rsp_valid", rsp_valid, 1'b1);
        check("w0_c3_psel", psel, 1'b0);
        check("w0_c3_rsp_err", rsp_err, 1'b0);
        check("w0_c3_rsp_rdata", rsp_rdata, 17'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w0_idle_rsp_valid", rsp_valid, 1'b0);
        check("w0_idle_cmd_ready", cmd_ready, 1'b1);

        // Read with three wait cycles; stray pslverr while pready is low is ignored.
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'h0001_2345;
        issue(1'b0, 32'h20, 17'h0);
        check("r1_setup_pwrite", pwrite, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin
                pready  = 1'b1;
                pslverr = 1'b0;
                prdata  = 32'h0001FFFF;
            end
            check("r1_acc_psel", psel, 1'b1);
            check("r1_acc_penable", penable, 1'b1);
            check("r1_acc_paddr", paddr, 32'h20);
        end
        step();
        prdata = 32'h0;
        check("r1_rsp_valid", rsp_valid, 1'b1);
        check("r1_rsp_rdata", rsp_rdata, 17'h1FFFF);
        check("r1_rsp_err", rsp_err, 1'b0);

        // Stall the response 5 cycles while a new command waits to be accepted.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 17'h00055;
        pslverr   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_rdata", rsp_rdata, 17'h1FFFF);
            check("stall_cmd_ready", cmd_ready, 1'b0);
            check("stall_psel", psel, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("pend_idle_cmd_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        check("pend_psel", psel, 1'b1);
        check("pend_paddr", paddr, 32'h30);
        check("pend_pwdata", pwdata, 32'h00000055);
        step();
        step();
        pslverr = 1'b0;
        check("slverr_rsp_err", rsp_err, 1'b1);
        check("slverr_rsp_rdata", rsp_rdata, 17'h0);

        // A command offered during the error response waits for rsp_ready.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 17'h10001;
        for (int i = 0; i < 2; i++) begin
            step();
            check("errwait_cmd_ready", cmd_ready, 1'b0);
            check("errwait_psel", psel, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("w2_paddr", paddr, 32'h40);
        check("w2_pwdata", pwdata, 32'h00010001);
        step();
        step();
        check("w2_rsp_valid", rsp_valid, 1'b1);
        check("w2_rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        step();

        // Back-to-back reads with rsp_ready tied high: one transfer every 4 cycles.
        prdata    = 32'hFFFE_0ABC;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h50;
        for (int i = 0; i < 8; i++) begin
            step();
            check("b2b_psel", psel, ((i % 4) < 2));
            check("b2b_rsp_valid", rsp_valid, ((i % 4) == 2));
            if ((i % 4) == 2) check("b2b_rsp_rdata", rsp_rdata, 17'h00ABC);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_end_cmd_ready", cmd_ready, 1'b1);

        // Reset pulsed in ACCESS drops the bus at once and yields no response.
        pready = 1'b0;
        issue(1'b0, 32'h70, 17'h0);
        step();
        check("rstmid_acc_penable", penable, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_psel", psel, 1'b0);
        check("rstmid_penable", penable, 1'b0);
        check("rstmid_paddr", paddr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        pready = 1'b1;
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_no_rsp", rsp_valid, 1'b0);
            check("rstmid_no_psel", psel, 1'b0);
        end

`ifdef APB_MST_TMO_EN
        // Prime rsp_rdata with a nonzero read, then let a silent slave time out.
        prdata    = 32'h0000_1234;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h58, 17'h0);
        step();
        step();
        check("tmo_prime_rdata", rsp_rdata, 17'h01234);
        step();
        rsp_ready = 1'b0;
        pready    = 1'b0;
        issue(1'b0, 32'h60, 17'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("tmo_acc_penable", penable, 1'b1);
        end
        step();
        check("tmo_rsp_valid", rsp_valid, 1'b1);
        check("tmo_psel", psel, 1'b0);
        check("tmo_rsp_err", rsp_err, 1'b1);
        check("tmo_rsp_rdata", rsp_rdata, 17'h0);
`else
        // Without the timeout the master waits in ACCESS for as long as pready stays low.
        pready = 1'b0;
        issue(1'b0, 32'h60, 17'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("notmo_penable", penable, 1'b1);
            check("notmo_rsp_valid", rsp_valid, 1'b0);
        end
        pready = 1'b1;
        prdata = 32'h0000_0777;
        step();
        check("notmo_rsp_valid_end", rsp_valid, 1'b1);
        check("notmo_rsp_rdata", rsp_rdata, 17'h00777);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_pix_master.md
APB_PIX_MASTER -- requirements
Module: apb_pix_master

Interface
REQ-001 Parameter: ADDR_W, 32, APB address width.
REQ-002 Parameter: DATA_W, 32, APB data width; pixel payload occupies bits [16:0].
REQ-003 Parameter: TMO_CYC, 255, max ACCESS wait cycles before abort (used only with APB_MST_TMO_EN).
REQ-004 clk  in  1  single clock; all logic on rising edge; APB pclk is clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  17  pixel to write (signed lifting sample).
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  out  17  read pixel (prdata[16:0]); 0 for writes.
REQ-014 rsp_err  out  1  pslverr, or timeout, of the completed transfer.
REQ-015 psel, penable, pwrite  out  1 each  APB control.
REQ-016 paddr  out  ADDR_W; pwdata  out  DATA_W, bits [31:17] zero.
REQ-017 prdata  in  DATA_W; pready  in  1; pslverr  in  1.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, RESP.
REQ-019 IDLE: cmd_ready=1; on accept, register cmd fields into paddr/pwrite/pwdata, go SETUP.
REQ-020 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-021 ACCESS: psel=1, penable=1; hold paddr/pwrite/pwdata stable until pready=1.
REQ-022 ACCESS with pready=1: capture prdata[16:0] (reads only) and pslverr into rsp regs, drop psel/penable next cycle, go RESP.
REQ-023 RESP: rsp_valid=1; hold rsp_rdata/rsp_err stable until rsp_ready; on handshake go IDLE.
REQ-024 cmd_ready=0 in SETUP, ACCESS, RESP; no command buffering (one outstanding transfer).
REQ-025 Zero-wait slave (pready=1 in first ACCESS cycle): accept-to-rsp_valid latency = 3 cycles; back-to-back throughput one transfer per 4 cycles with rsp_ready tied high.
REQ-026 cmd_valid asserted in non-IDLE states is ignored and not lost; it is accepted on the next IDLE cycle.
REQ-027 pslverr sampled only when psel && penable && pready; ignored otherwise.
REQ-028 Write responses: rsp_rdata=0.

Reset
REQ-029 rst asserted: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, immediately (asynchronous).
REQ-030 rst mid-transfer aborts the APB transfer with no response issued; cmd_ready=1 on first cycle after release.

Configuration
REQ-031 Macro APB_MST_TMO_EN defined: an 8-bit-or-wider counter counts ACCESS cycles with pready=0; on reaching TMO_CYC, abort (psel/penable drop), go RESP with rsp_err=1, rsp_rdata=0.
REQ-032 Macro APB_MST_TMO_EN undefined: no counter logic; ACCESS waits indefinitely for pready.

Structure
REQ-033 Shared package apb_pix_pkg holds FSM state enum, pixel width constant (PIX_W=17), and the APB command record typedef.
REQ-034 Single module; no sub-modules; the timeout counter is inline.

Verification
REQ-035 Zero-wait write addr 0x10 data 0x1ABCD -> psel rises cycle 1, penable cycle 2, pwdata=0x0001ABCD, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x20 with pready low 3 ACCESS cycles, prdata=0x0001FFFF -> paddr stable 4 ACCESS cycles, rsp_rdata=0x1FFFF, rsp_err=0.
REQ-037 Write with pslverr=1 at pready -> rsp_err=1; next command accepted only after rsp_ready.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout, no new psel.
REQ-039 rst pulsed during ACCESS -> psel=penable=0 same cycle, no rsp_valid, cmd_ready=1 after release.
REQ-040 APB_MST_TMO_EN, TMO_CYC=4, pready never high -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0.
